// File: rtl/arb_client_if.sv
// Handshake bundle between an arb_client and its command source / arbiter port.
// master: the arb_client side; slave: the command source + arbiter side.
interface arb_client_if #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 3
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_data;
    logic [LEN_W-1:0]  cmd_len;
    logic              req;
    logic              gnt;
    logic              bus_valid;
    logic [DATA_W-1:0] bus_data;
    logic              bus_last;
    logic              busy;
    logic              timeout_err;

    modport master (
        input  cmd_valid,
        input  cmd_data,
        input  cmd_len,
        input  gnt,
        output cmd_ready,
        output req,
        output bus_valid,
        output bus_data,
        output bus_last,
        output busy,
        output timeout_err
    );

    modport slave (
        output cmd_valid,
        output cmd_data,
        output cmd_len,
        output gnt,
        input  cmd_ready,
        input  req,
        input  bus_valid,
        input  bus_data,
        input  bus_last,
        input  busy,
        input  timeout_err
    );
endinterface

// File: rtl/arb_client.sv
// Requester front end for a round-robin arbiter port: command FIFO + req/gnt burst FSM.
// Optional grant-wait watchdog enabled by defining ARB_CLIENT_TIMEOUT_EN.
module arb_client #(
    parameter int DATA_W  = 8,
    parameter int LEN_W   = 3,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    arb_client_if.master bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_XFER,
        S_REL
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [LEN_W-1:0]  len;
    } cmd_t;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("arb_client: DEPTH must be a power of 2 and >= 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("arb_client: TIMEOUT must be >= 1");
    end

    cmd_t            r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;
    state_t          r_state;
    logic [LEN_W-1:0] r_beat;

    cmd_t            w_head;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_fire;
    logic            w_last;

    assign w_head  = r_mem[r_rptr];
    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = bus.cmd_valid && !w_full;
    assign w_fire  = (r_state == S_XFER) && bus.gnt;
    assign w_last  = w_fire && (r_beat == w_head.len);
    assign w_pop   = w_last;

    // FIFO storage: payload only, no reset needed since count gates every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= '{data: bus.cmd_data, len: bus.cmd_len};
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keeps the count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Request/transfer FSM with the beat counter; stalls in XFER hold the beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_beat  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.gnt) begin
                        r_state <= S_XFER;
                        r_beat  <= '0;
                    end
                end
                S_XFER: begin
                    if (bus.gnt) begin
                        if (r_beat == w_head.len) begin
                            r_state <= S_REL;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
                S_REL: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ARB_CLIENT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] r_wait;
    logic          r_terr;

    // Grant-wait watchdog: idle outside REQ, restarts on grant or on expiry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait <= '0;
            r_terr <= 1'b0;
        end else begin
            r_terr <= 1'b0;
            if (r_state != S_REQ || bus.gnt) begin
                r_wait <= '0;
            end else if (r_wait == TW'(TIMEOUT - 1)) begin
                r_wait <= '0;
                r_terr <= 1'b1;
            end else begin
                r_wait <= r_wait + 1'b1;
            end
        end
    end

    assign bus.timeout_err = r_terr;
`else
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.cmd_ready = !w_full;
    assign bus.req       = (r_state == S_REQ) || (r_state == S_XFER);
    assign bus.bus_valid = w_fire;
    assign bus.bus_data  = w_fire ? (w_head.data + DATA_W'(r_beat)) : '0;
    assign bus.bus_last  = w_last;
    assign bus.busy      = !w_empty || (r_state != S_IDLE);
endmodule
